// File: rtl/sisc_pkg.sv
// Shared SISC constants: opcodes, addressing modes, controller state codes
// and a small opcode classifier used by the control FSM.
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [3:0] AM_IMM  = 4'd8;

  localparam logic [2:0] ST_START    = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_DECODE   = 3'd2;
  localparam logic [2:0] ST_EXECUTE  = 3'd3;
  localparam logic [2:0] ST_MEM      = 3'd4;
  localparam logic [2:0] ST_MEM_WAIT = 3'd5;
  localparam logic [2:0] ST_WB       = 3'd6;
  localparam logic [2:0] ST_HALT     = 3'd7;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MEM,
    CLS_BR,
    CLS_RF,
    CLS_HLT
  } op_cls_e;

  // Undefined opcodes fall into CLS_NOP so they retire straight from DECODE.
  function automatic op_cls_e op_class(input logic [3:0] opc);
    op_cls_e cls;
    case (opc)
      OP_LOD, OP_STR:                 cls = CLS_MEM;
      OP_BRA, OP_BRR, OP_BNE, OP_BNR: cls = CLS_BR;
      OP_SWP, OP_ALU:                 cls = CLS_RF;
      OP_HLT:                         cls = CLS_HLT;
      default:                        cls = CLS_NOP;
    endcase
    return cls;
  endfunction

  function automatic logic is_rel_br(input logic [3:0] opc);
    return (opc == OP_BRR) || (opc == OP_BNR);
  endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluator: a zero mask is unconditional, otherwise
// BRA/BRR take on any masked flag set and BNE/BNR take on none set.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int STAT_W = 4
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [STAT_W-1:0] mm,
  input  logic [STAT_W-1:0] stat,
  output logic              taken
);

  logic hit;
  logic br_pos;
  logic br_neg;

  assign hit    = |(stat & mm);
  assign br_pos = (opcode == OPC_W'(OP_BRA)) || (opcode == OPC_W'(OP_BRR));
  assign br_neg = (opcode == OPC_W'(OP_BNE)) || (opcode == OPC_W'(OP_BNR));
  assign taken  = (mm == '0) || (br_pos && hit) || (br_neg && !hit);

endmodule

// File: rtl/sisc_ctrl_mc.sv
// Multicycle SISC control FSM: fetch/decode/execute/mem/writeback sequencing
// with a memory request/ack handshake, wait-state timeout and sticky HALT.
module sisc_ctrl_mc
  import sisc_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int STAT_W  = 4,
  parameter int ALUOP_W = 2,
  parameter int TMO_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [STAT_W-1:0]  mm,
  input  logic [STAT_W-1:0]  stat,
  input  logic               mem_ack,
  output logic               rf_we,
  output logic               wb_sel,
  output logic               rd_sel,
  output logic               br_sel,
  output logic               pc_rst,
  output logic               pc_write,
  output logic               pc_sel,
  output logic               ir_load,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_req,
  output logic               mem_we,
  output logic               halted,
  output logic               bus_err,
  output logic [2:0]         state_o
);

  // The counter is cleared on entry to MEM_WAIT, so reaching all-ones after
  // the increment marks the (2**TMO_W-1)-th unanswered wait cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  logic [2:0]        state_reg, state_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic              bus_err_reg, bus_err_next;
  logic [OPC_W-1:0]  opcode_q;
  logic [STAT_W-1:0] mm_q;
  op_cls_e           cls_dec, cls_q;
  logic              taken;

  assign cls_dec = op_class(4'(opcode));
  assign cls_q   = op_class(4'(opcode_q));

  sisc_br_cond #(
    .OPC_W  (OPC_W),
    .STAT_W (STAT_W)
  ) u_br_cond (
    .opcode (opcode_q),
    .mm     (mm_q),
    .stat   (stat),
    .taken  (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_START;
      tmo_cnt_reg <= '0;
      bus_err_reg <= 1'b0;
      opcode_q    <= '0;
      mm_q        <= '0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
      bus_err_reg <= bus_err_next;
      if (state_reg == ST_DECODE) begin
        opcode_q <= opcode;
        mm_q     <= mm;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = tmo_cnt_reg;
    bus_err_next = bus_err_reg;
    case (state_reg)
      ST_START:   if (run) state_next = ST_FETCH;
      ST_FETCH:   if (run) state_next = ST_DECODE;
      ST_DECODE: begin
        case (cls_dec)
          CLS_HLT:                  state_next = ST_HALT;
          CLS_MEM, CLS_BR, CLS_RF:  state_next = ST_EXECUTE;
          default:                  state_next = ST_FETCH;
        endcase
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_MEM: state_next = ST_MEM;
          CLS_RF:  state_next = ST_WB;
          default: state_next = ST_FETCH;
        endcase
      end
      ST_MEM, ST_MEM_WAIT: begin
        tmo_cnt_next = (state_reg == ST_MEM) ? '0 : tmo_cnt_reg + TMO_W'(1);
        // An ack arriving on the timeout cycle still completes the access.
        if (mem_ack) begin
          state_next = (opcode_q == OPC_W'(OP_LOD)) ? ST_WB : ST_FETCH;
        end else if (state_reg == ST_MEM) begin
          state_next = ST_MEM_WAIT;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          bus_err_next = 1'b1;
          state_next   = ST_HALT;
        end
      end
      ST_WB:      state_next = ST_FETCH;
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_START;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b1;
    rd_sel   = 1'b0;
    br_sel   = 1'b1;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b1;
    ir_load  = 1'b0;
    alu_op   = ALUOP_W'(2'b10);
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    case (state_reg)
      ST_START:   pc_rst = 1'b1;
      ST_FETCH: begin
        pc_sel   = 1'b0;
        pc_write = run;
        ir_load  = run;
      end
      // DECODE sees the fresh IR, so it steers br_sel from the live opcode.
      ST_DECODE:  br_sel = !is_rel_br(4'(opcode));
      ST_EXECUTE: begin
        alu_op[0] = (mm_q == STAT_W'(AM_IMM));
        alu_op[1] = (opcode_q != OPC_W'(OP_ALU));
        rd_sel    = (cls_q == CLS_MEM);
        br_sel    = !is_rel_br(4'(opcode_q));
        if (cls_q == CLS_BR) pc_write = taken;
      end
      ST_MEM, ST_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = (opcode_q == OPC_W'(OP_STR));
      end
      ST_WB: begin
        rf_we  = (cls_q == CLS_RF) || (opcode_q == OPC_W'(OP_LOD));
        wb_sel = (opcode_q == OPC_W'(OP_LOD));
      end
      ST_HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign bus_err = bus_err_reg;
  assign state_o = state_reg;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Randomised instruction-level bench for sisc_ctrl_mc: each instruction is
// expanded into expected per-cycle control words and checked by a monitor.
module tb_sisc_ctrl_mc;
  import sisc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = '0;
  logic [3:0] mm = '0;
  logic [3:0] stat = '0;
  logic       mem_ack = 1'b0;
  logic       rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
  logic [1:0] alu_op;
  logic       mem_req, mem_we, halted, bus_err;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  sisc_ctrl_mc #(
    .OPC_W   (4),
    .STAT_W  (4),
    .ALUOP_W (2),
    .TMO_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .mem_ack  (mem_ack),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .rd_sel   (rd_sel),
    .br_sel   (br_sel),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .ir_load  (ir_load),
    .alu_op   (alu_op),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .halted   (halted),
    .bus_err  (bus_err),
    .state_o  (state_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
    logic [1:0] alu_op;
    logic mem_req, mem_we, halted, bus_err;
  } exp_t;

  typedef struct packed {
    logic chk;
    exp_t e;
  } sb_t;

  sb_t  sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic berr_m = 1'b0;

  function automatic exp_t dflt(input logic [2:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    e.wb_sel = 1'b1;
    e.br_sel = 1'b1;
    e.pc_sel = 1'b1;
    e.alu_op = 2'b10;
    e.bus_err = berr_m;
    return e;
  endfunction

  function automatic logic ref_taken(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
    logic any_hit;
    any_hit = (s & m) != 4'd0;
    if (m == 4'd0) return 1'b1;
    if (op == OP_BRA || op == OP_BRR) return any_hit;
    if (op == OP_BNE || op == OP_BNR) return !any_hit;
    return 1'b0;
  endfunction

  function automatic string st_name(input logic [2:0] s);
    case (s)
      3'd0: return "START";
      3'd1: return "FETCH";
      3'd2: return "DECODE";
      3'd3: return "EXECUTE";
      3'd4: return "MEM";
      3'd5: return "MEM_WAIT";
      3'd6: return "WB";
      default: return "HALT";
    endcase
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic step(input logic r, input logic rn, input logic ak, input logic [3:0] op,
                      input logic [3:0] m, input logic [3:0] sv, input logic chk, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; run = rn; mem_ack = ak; opcode = op; mm = m; stat = sv;
    sb_q.push_back({chk, e});
  endtask

  task automatic restart();
    exp_t e;
    step(1'b1, rb(), rb(), rnd4(), rnd4(), rnd4(), 1'b0, dflt(3'd0));
    berr_m = 1'b0;
    e = dflt(3'd0);
    e.pc_rst = 1'b1;
    repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, rb(), rnd4(), rnd4(), rnd4(), 1'b1, e);
    step(1'b0, 1'b1, rb(), rnd4(), rnd4(), rnd4(), 1'b1, e);
  endtask

  // Expands one instruction from the FETCH boundary; dly is the MEM_WAIT
  // cycle carrying mem_ack (0 = ack in MEM, >15 = never), abort_at resets
  // the controller before that wait cycle.
  task automatic do_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] sv,
                          input int stall, input int dly, input int abort_at);
    exp_t e;
    int   nwait;
    $display("instr op=%0d mm=%b stat=%b stall=%0d ack_dly=%0d abort=%0d", op, m, sv, stall, dly, abort_at);
    for (int k = 0; k < stall; k++) begin
      e = dflt(3'd1);
      e.pc_sel = 1'b0;
      step(1'b0, 1'b0, rb(), rnd4(), rnd4(), rnd4(), 1'b1, e);
    end
    e = dflt(3'd1);
    e.pc_sel = 1'b0; e.pc_write = 1'b1; e.ir_load = 1'b1;
    step(1'b0, 1'b1, rb(), rnd4(), rnd4(), rnd4(), 1'b1, e);
    e = dflt(3'd2);
    e.br_sel = !(op == OP_BRR || op == OP_BNR);
    step(1'b0, rb(), rb(), op, m, rnd4(), 1'b1, e);
    if (op == OP_HLT) begin
      e = dflt(3'd7);
      e.halted = 1'b1;
      repeat ($urandom_range(3, 6)) step(1'b0, rb(), rb(), rnd4(), rnd4(), rnd4(), 1'b1, e);
      restart();
      return;
    end
    if (op == OP_NOOP || op > OP_ALU) return;
    e = dflt(3'd3);
    e.alu_op = {op != OP_ALU, m == AM_IMM};
    e.rd_sel = (op == OP_LOD || op == OP_STR);
    e.br_sel = !(op == OP_BRR || op == OP_BNR);
    if (op >= OP_BRA && op <= OP_BNR) e.pc_write = ref_taken(op, m, sv);
    step(1'b0, rb(), rb(), rnd4(), rnd4(), sv, 1'b1, e);
    if (op >= OP_BRA && op <= OP_BNR) return;
    if (op == OP_LOD || op == OP_STR) begin
      e = dflt(3'd4);
      e.mem_req = 1'b1; e.mem_we = (op == OP_STR);
      step(1'b0, rb(), dly == 0, rnd4(), rnd4(), rnd4(), 1'b1, e);
      nwait = (dly > 15) ? 15 : dly;
      for (int i = 1; i <= nwait; i++) begin
        if (i == abort_at) begin
          restart();
          return;
        end
        e = dflt(3'd5);
        e.mem_req = 1'b1; e.mem_we = (op == OP_STR);
        step(1'b0, rb(), i == dly, rnd4(), rnd4(), rnd4(), 1'b1, e);
      end
      if (dly > 15) begin
        berr_m = 1'b1;
        e = dflt(3'd7);
        e.halted = 1'b1;
        repeat ($urandom_range(2, 4)) step(1'b0, rb(), rb(), rnd4(), rnd4(), rnd4(), 1'b1, e);
        restart();
        return;
      end
      if (op == OP_STR) return;
    end
    e = dflt(3'd6);
    e.rf_we = 1'b1;
    e.wb_sel = (op == OP_LOD);
    step(1'b0, rb(), rb(), rnd4(), rnd4(), rnd4(), 1'b1, e);
  endtask

  initial begin : monitor
    sb_t  s;
    exp_t act;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        s = sb_q.pop_front();
        if (s.chk) begin
          act = {state_o, rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
                 alu_op, mem_req, mem_we, halted, bus_err};
          n_chk++;
          if (act === s.e) n_pass++;
          else $display("FAIL ctrl_%s t=%0t actual=%h required=%h", st_name(s.e.st), $time, act, s.e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int dly, abort_at, op;
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, dflt(3'd0));
    restart();
    do_instr(OP_ALU, 4'b0000, rnd4(), 0, 0, 0);
    do_instr(OP_BRA, 4'b0010, 4'b0010, 0, 0, 0);
    do_instr(OP_BRA, 4'b0010, 4'b0000, 0, 0, 0);
    do_instr(OP_BNR, 4'b0001, 4'b0000, 0, 0, 0);
    do_instr(OP_BNE, 4'b0000, 4'b1111, 0, 0, 0);
    do_instr(OP_LOD, 4'b1000, rnd4(), 3, 3, 0);
    do_instr(OP_STR, 4'b0001, rnd4(), 0, 15, 0);
    do_instr(OP_LOD, 4'b0100, rnd4(), 0, 5, 2);
    do_instr(OP_STR, 4'b0011, rnd4(), 0, 16, 0);
    do_instr(4'd11, rnd4(), rnd4(), 1, 0, 0);
    do_instr(OP_NOOP, rnd4(), rnd4(), 0, 0, 0);
    do_instr(OP_SWP, AM_IMM, rnd4(), 0, 0, 0);
    do_instr(OP_HLT, rnd4(), rnd4(), 0, 0, 0);
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 15);
      dly = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      abort_at = 0;
      if (dly > 0 && $urandom_range(0, 15) == 0) abort_at = $urandom_range(1, (dly > 15) ? 15 : dly);
      do_instr(4'(op), ($urandom_range(0, 3) == 0) ? 4'd0 : rnd4(), rnd4(),
               $urandom_range(0, 2), dly, abort_at);
    end
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
